bus_arbiter_four: RTL and testbench

Round-robin arbiter that shares one 8-bit datapath bus between four requesters. It generates the select for a 4:1 bus multiplexer, with the same select encoding as `mux_four`, and drives the muxed bus with a valid flag. It also enforces a bounded hold time so that no requester can starve the others. It sits between the register/ALU sources and the shared internal bus of the MPU.

---
 rtl/bus_arbiter_four.sv | 119 +++++++++++
 tb/tb_bus_arbiter_four.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_four.sv
// Four-way round-robin bus arbiter with bounded hold time.
// Drives a one-hot registered grant, the 4:1 mux select and the gated shared bus.
module bus_arbiter_four #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    grant_q, grant_d;

  // Returns {found, index}: first set bit scanning ptr+1 .. ptr+4 (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      c = ptr + 2'(k);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  logic [3:0] owner_oh, others;
  logic [2:0] pick_all, pick_oth;

  always_comb begin
    owner_oh = 4'b0001 << owner_q;
    others   = req & ~owner_oh;
    pick_all = rr_pick(req, last_q);
    pick_oth = rr_pick(others, last_q);

    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          state_d = GRANT;
          owner_d = pick_all[1:0];
          last_d  = pick_all[1:0];
          hold_d  = HW'(1);
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          // Owner released; hand straight to the next requester if one waits.
          if (pick_all[2]) begin
            owner_d = pick_all[1:0];
            last_d  = pick_all[1:0];
            hold_d  = HW'(1);
          end else begin
            state_d = IDLE;
          end
        end else if (hold_q < HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end else if (pick_oth[2]) begin
          owner_d = pick_oth[1:0];
          last_d  = pick_oth[1:0];
          hold_d  = HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    grant_d = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 2'b00;
      last_q  <= 2'b11;
      hold_q  <= '0;
      grant_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      grant_q <= grant_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = owner_q;
  assign bus_valid = |grant_q;

  always_comb begin
    bus_out = '0;
    if (bus_valid) begin
      case (sel)
        2'b00:   bus_out = data_a;
        2'b01:   bus_out = data_b;
        2'b10:   bus_out = data_c;
        default: bus_out = data_d;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter_four.sv
// Randomized + directed bench for bus_arbiter_four against an abstract
// round-robin/hold-limit model.
module tb_bus_arbiter_four;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       req;
  logic [WIDTH-1:0] data_a, data_b, data_c, data_d;
  logic [3:0]       grant;
  logic [1:0]       sel;
  logic [WIDTH-1:0] bus_out;
  logic             bus_valid;

  bus_arbiter_four #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req),
    .data_a(data_a), .data_b(data_b), .data_c(data_c), .data_d(data_d),
    .grant(grant), .sel(sel), .bus_out(bus_out), .bus_valid(bus_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, whose turn is next, how long held.
  bit m_busy;
  int m_owner, m_last, m_hold;

  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 3; m_hold = 0;
  endtask

  task automatic take(input int w);
    m_busy = 1; m_owner = w; m_last = w; m_hold = 1;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    if (!m_busy) begin
      if (r != 0) take(pick(r, m_last));
    end else if (!r[m_owner]) begin
      if (r != 0) take(pick(r, m_last));
      else m_busy = 0;
    end else if (m_hold < MAX_HOLD) begin
      m_hold++;
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (oth != 0) take(pick(oth, m_last));
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_bus();
    if (!m_busy) return '0;
    case (m_owner)
      0: return data_a;
      1: return data_b;
      2: return data_c;
      default: return data_d;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".grant"}, 32'(grant), m_busy ? 32'(1 << m_owner) : 32'd0);
    chk({tag, ".sel"}, 32'(sel), 32'(m_owner));
    chk({tag, ".valid"}, 32'(bus_valid), 32'(m_busy));
    chk({tag, ".bus"}, 32'(bus_out), 32'(exp_bus()));
    chk({tag, ".onehot"}, 32'($onehot0(grant)), 32'd1);
  endtask

  task automatic cycle(input string tag);
    model_step(req);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".grant0"}, 32'(grant), 32'd0);
    chk({tag, ".sel0"}, 32'(sel), 32'd0);
    chk({tag, ".valid0"}, 32'(bus_valid), 32'd0);
    chk({tag, ".bus0"}, 32'(bus_out), 32'd0);
  endtask

  // Async reset pulse from mid-cycle; released on the next falling edge.
  task automatic pulse_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_zero(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    data_a = 8'h11; data_b = 8'h22; data_c = 8'h33; data_d = 8'h44;
    model_reset();
    #2 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fairness: full contention rotates 0,1,2,3,0 with MAX_HOLD cycles each.
    for (int n = 0; n < 20; n++) begin
      cycle("fair");
      chk("fair.seq", 32'(grant), 32'(1 << ((n / MAX_HOLD) % 4)));
    end

    // Single request from c.
    data_c = 8'hAA;
    req = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      cycle("single");
      chk("single.grant", 32'(grant), 32'h4);
      chk("single.bus", 32'(bus_out), 32'hAA);
    end
    req = 4'b0000;
    cycle("release");
    chk("release.grant", 32'(grant), 32'h0);
    chk("release.sel", 32'(sel), 32'h2);

    // Gapless handoff from b to waiting d.
    req = 4'b0010;
    cycle("hand_a");
    req = 4'b1010;
    cycle("hand_b");
    chk("hand.own1", 32'(grant), 32'h2);
    req = 4'b1000;
    cycle("hand_c");
    chk("hand.grant", 32'(grant), 32'h8);
    chk("hand.sel", 32'(sel), 32'h3);
    chk("hand.valid", 32'(bus_valid), 32'h1);

    // Solo hold never drops at the MAX_HOLD boundary.
    req = 4'b0001;
    for (int n = 0; n < 10; n++) begin
      cycle("solo");
      chk("solo.grant", 32'(grant), 32'h1);
    end

    // Combinational data path follows the live selected input.
    data_a = 8'h5C;
    #1 chk("comb.bus", 32'(bus_out), 32'h5C);

    // Mid-grant reset restarts from the reset pointer.
    req = 4'b0100;
    cycle("pre_rst");
    chk("pre_rst.grant", 32'(grant), 32'h4);
    pulse_reset("midrst");
    req = 4'b0110;
    cycle("post_rst");
    chk("post_rst.grant", 32'(grant), 32'h2);

    // Randomized traffic with sticky requests and occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3, 0) == 0) req = 4'($urandom);
      cycle("rand");
      data_a = 8'($urandom); data_b = 8'($urandom);
      data_c = 8'($urandom); data_d = 8'($urandom);
      #1 chk("rand.bus", 32'(bus_out), 32'(exp_bus()));
      if ($urandom_range(99, 0) == 0) pulse_reset("rand_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
